// File: rtl/div_pow2_pkg.sv
// Shared types and helpers for the serial signed divide-by-2^s block.
package div_pow2_pkg;

  localparam int unsigned DIV_POW2_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } div_pow2_state_t;

  // Limit the shift count to the largest meaningful shift for an n-bit operand.
  function automatic int unsigned clamp_shift(input int unsigned s_val, input int unsigned n);
    return (s_val >= n) ? (n - 1) : s_val;
  endfunction

endpackage

// File: rtl/serial_signed_divide_by_power_of_2_if.sv
// Operand/result handshake bundle for serial_signed_divide_by_power_of_2.
interface serial_signed_divide_by_power_of_2_if
  import div_pow2_pkg::*;
#(
  parameter int unsigned N  = DIV_POW2_N_DEFAULT,
  parameter int unsigned SW = $clog2(N)
) ();

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [SW-1:0] s;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  res;

  modport master (
    output in_valid, a, s, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, a, s, out_ready,
    output in_ready, out_valid, res
  );

endinterface

// File: rtl/div_pow2_round_fix.sv
// Final-step correction for the serial divider.
// SERIAL_DIV_POW2_ROUND_TO_ZERO_EN selects truncation toward zero
// (+1 on negative inexact results); otherwise the floor value passes through.
module div_pow2_round_fix #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] shifted_i,
  input  logic         sign_i,
  input  logic         sticky_i,
  output logic [N-1:0] fixed_o
);

`ifdef SERIAL_DIV_POW2_ROUND_TO_ZERO_EN
  // Negative, inexact result: step one toward zero (cannot overflow).
  always_comb begin
    fixed_o = shifted_i + {{(N-1){1'b0}}, (sign_i & sticky_i)};
  end
`else
  logic unused_round_inputs;
  assign unused_round_inputs = sign_i ^ sticky_i;

  // Floor result: arithmetic shift output is already final.
  always_comb begin
    fixed_o = shifted_i;
  end
`endif

endmodule

// File: rtl/serial_signed_divide_by_power_of_2.sv
// Multi-cycle signed divide by 2^s, one arithmetic right shift per clock.
// Optional macro SERIAL_DIV_POW2_ROUND_TO_ZERO_EN: truncate toward zero
// instead of flooring.
module serial_signed_divide_by_power_of_2
  import div_pow2_pkg::*;
#(
  parameter int unsigned N  = DIV_POW2_N_DEFAULT,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  serial_signed_divide_by_power_of_2_if.slave bus
);

  div_pow2_state_t state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic [N-1:0]    res_q, res_d;

  logic [N-1:0]    shifted;
  logic            sticky_all;
  logic [N-1:0]    fixed;
  logic [SW-1:0]   cnt_clamped;

  assign shifted     = {acc_q[N-1], acc_q[N-1:1]};
  assign sticky_all  = sticky_q | acc_q[0];
  assign cnt_clamped = SW'(clamp_shift(32'(bus.s), N));

  div_pow2_round_fix #(.N(N)) u_round_fix (
    .shifted_i (shifted),
    .sign_i    (shifted[N-1]),
    .sticky_i  (sticky_all),
    .fixed_o   (fixed)
  );

  // State, datapath and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
    end
  end

  // Next-state and datapath updates for accept, shift and hand-off.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    res_d    = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d    = bus.a;
          cnt_d    = cnt_clamped;
          sticky_d = 1'b0;
          state_d  = (cnt_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d    = shifted;
        sticky_d = sticky_all;
        cnt_d    = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          acc_d   = fixed;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // res is a separate register so it only moves on the edge entering DONE.
    if (state_d == DONE && state_q != DONE) begin
      res_d = acc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;

endmodule

// File: tb/tb_serial_signed_divide_by_power_of_2.sv
// Directed scoreboard bench for serial_signed_divide_by_power_of_2 (N=8).
module tb_serial_signed_divide_by_power_of_2;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;

`ifdef SERIAL_DIV_POW2_ROUND_TO_ZERO_EN
  localparam logic [7:0] EXP_M100_S3 = 8'hF4;  // -12
  localparam logic [7:0] EXP_M1_S7   = 8'h00;  //   0
`else
  localparam logic [7:0] EXP_M100_S3 = 8'hF3;  // -13
  localparam logic [7:0] EXP_M1_S7   = 8'hFF;  //  -1
`endif

  logic clk = 1'b0;
  logic rst;

  serial_signed_divide_by_power_of_2_if #(.N(N), .SW(SW)) bus ();

  serial_signed_divide_by_power_of_2 #(.N(N), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completed output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(bus.res), 64'hDEAD);
      end else begin
        chk("res", 64'(bus.res), 64'(exp_q.pop_front()));
      end
    end
  end

  // Issue one operand (called at posedge+1); returns once out_valid is seen.
  task automatic issue(input logic [7:0] av, input logic [2:0] sv, input logic [7:0] ev,
                       input int unsigned exp_lat);
    int unsigned w;
    int unsigned lat;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.s        = sv;
    exp_q.push_back(ev);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.s         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_res",       64'(bus.res),       64'd0);

    // Basic vectors: a, s, expected res, accept-to-valid latency
    issue(8'h9C, 3'd3, EXP_M100_S3, 4);   // -100 / 8
    issue(8'h64, 3'd3, 8'h0C,       4);   //  100 / 8 = 12
    issue(8'h80, 3'd7, 8'hFF,       8);   // -128 / 128 = -1 exact
    issue(8'hFF, 3'd7, EXP_M1_S7,   8);   //   -1 / 128
    issue(8'h80, 3'd0, 8'h80,       1);   // s=0 passes a through
    issue(8'h07, 3'd1, 8'h03,       2);   //    7 / 2 = 3

    // Backpressure: hold result in DONE
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(8'h9C, 3'd3, EXP_M100_S3, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res",       64'(bus.res),       64'(EXP_M100_S3));
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // Back-to-back operands
    issue(8'h9C, 3'd3, EXP_M100_S3, 4);
    issue(8'h64, 3'd3, 8'h0C,       4);

    // Reset during the second SHIFT cycle discards the operand
    @(posedge clk); #1;
    while (!bus.in_ready) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.a        = 8'h9C;
    bus.s        = 3'd5;
    @(posedge clk); #1;             // accept edge, now in first SHIFT cycle
    bus.in_valid = 1'b0;
    @(posedge clk); #1;             // second SHIFT cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    issue(8'h40, 3'd2, 8'h10, 3);   // 64 / 4 = 16

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
